// File: rtl/aes_uart_tx_ctrl.sv
// Round-robin arbiter and byte sequencer that shares one UART transmitter between
// the AES ciphertext path (requester 0) and the status/debug block (requester 1).
module aes_uart_tx_ctrl #(
    parameter int DATA_W = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_done_id
);

    localparam int NUM_BYTES = DATA_W / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_id_q, gnt_id_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              ready0_q, ready0_d;
    logic              ready1_q, ready1_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              done_id_q, done_id_d;
    logic              pick1;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1 = i_req1_valid && (!i_req0_valid || !last_grant_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
        end
    end

    // Start and byte are registered on entry to SEND so the pulse coincides with SEND.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        unique case (state_q)
            IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    gnt_id_d     = pick1;
                    last_grant_d = pick1;
                    shift_d      = pick1 ? i_req1_data : i_req0_data;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    ready0_d     = !pick1;
                    ready1_d     = pick1;
                    tx_start_d   = 1'b1;
                    tx_data_d    = shift_d[DATA_W-1 -: 8];
                    state_d      = SEND;
                end
            end
            SEND: state_d = WAIT_HI;
            WAIT_HI: begin
                if (i_tx_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!i_tx_busy) begin
                    if (cnt_q == LAST_BYTE) begin
                        done_d    = 1'b1;
                        done_id_d = gnt_id_q;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        shift_d    = shift_q << 8;
                        cnt_d      = cnt_q + CNT_W'(1);
                        tx_start_d = 1'b1;
                        tx_data_d  = shift_d[DATA_W-1 -: 8];
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_req0_ready = ready0_q;
    assign o_req1_ready = ready1_q;
    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_done_id    = done_id_q;

endmodule

// File: tb/tb_aes_uart_tx_ctrl.sv
// Randomized bench: requester drivers, a UART transmitter model with random busy
// timing, and a block-level round-robin model that predicts grant order and bytes.
module tb_aes_uart_tx_ctrl;

    localparam int W  = 128;
    localparam int NB = W / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0Valid, req1Valid;
    logic [W-1:0] req0Data, req1Data;
    logic         req0Ready, req1Ready;
    logic         txStart;
    logic [7:0]   txData;
    logic         txBusy;
    logic         ctrlBusy, done, doneId;

    logic         v8, rdy80, rdy81, st8, busy8, obusy8, done8, did8;
    logic [7:0]   d8, td8;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [W-1:0] req0Q[$];
    logic [W-1:0] req1Q[$];
    logic [7:0]   gotBytes[$];
    int           doneQ[$];
    int           doneCyc[$];
    int           grantQ[$];
    int           grantCyc[$];
    logic [W-1:0] expBlocks[$];
    int           expOrder[$];
    int           lastGrant;

    bit txPending;
    int riseCnt, lenCnt;

    aes_uart_tx_ctrl #(.DATA_W(W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0Valid), .i_req0_data(req0Data), .o_req0_ready(req0Ready),
        .i_req1_valid(req1Valid), .i_req1_data(req1Data), .o_req1_ready(req1Ready),
        .o_tx_start(txStart), .o_tx_data(txData), .i_tx_busy(txBusy),
        .o_busy(ctrlBusy), .o_done(done), .o_done_id(doneId)
    );

    aes_uart_tx_ctrl #(.DATA_W(8)) dut8 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v8), .i_req0_data(d8), .o_req0_ready(rdy80),
        .i_req1_valid(1'b0), .i_req1_data(8'h00), .o_req1_ready(rdy81),
        .o_tx_start(st8), .o_tx_data(td8), .i_tx_busy(busy8),
        .o_busy(obusy8), .o_done(done8), .o_done_id(did8)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Requesters present the head of their queue and pop it once ready is seen.
    initial begin
        req0Valid = 1'b0; req1Valid = 1'b0; req0Data = '0; req1Data = '0;
        forever begin
            @(negedge clk);
            if (req0Ready && req0Q.size() > 0) void'(req0Q.pop_front());
            if (req1Ready && req1Q.size() > 0) void'(req1Q.pop_front());
            req0Valid = (req0Q.size() > 0);
            req1Valid = (req1Q.size() > 0);
            if (req0Q.size() > 0) req0Data = req0Q[0];
            if (req1Q.size() > 0) req1Data = req1Q[0];
        end
    end

    // Transmitter model: busy rises 1..3 cycles after a start, stays up 2..20 cycles.
    initial begin
        bit wasBusy;
        txBusy = 1'b0; txPending = 1'b0; riseCnt = 0; lenCnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                txBusy = 1'b0; txPending = 1'b0;
            end else begin
                wasBusy = txBusy || txPending;
                if (txPending) begin
                    if (riseCnt <= 1) begin txBusy = 1'b1; txPending = 1'b0; end
                    else riseCnt--;
                end else if (txBusy) begin
                    if (lenCnt <= 1) txBusy = 1'b0;
                    else lenCnt--;
                end
                if (txStart) begin
                    compared++;
                    if (wasBusy) begin
                        mismatched++;
                        $display("[TB] FAIL start_while_busy: start=%0b busy=1, required no start", txStart);
                    end
                    gotBytes.push_back(txData);
                    txPending = 1'b1;
                    riseCnt = $urandom_range(1, 3);
                    lenCnt  = $urandom_range(2, 20);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req0Ready) begin grantQ.push_back(0); grantCyc.push_back(cyc); end
                if (req1Ready) begin grantQ.push_back(1); grantCyc.push_back(cyc); end
                if (done) begin doneQ.push_back(int'(doneId)); doneCyc.push_back(cyc); end
            end
        end
    end

    task automatic clearRecords();
        gotBytes.delete(); doneQ.delete(); doneCyc.delete();
        grantQ.delete(); grantCyc.delete(); expBlocks.delete(); expOrder.delete();
    endtask

    task automatic doReset();
        rst = 1'b1;
        req0Q.delete(); req1Q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lastGrant = 1;
        clearRecords();
    endtask

    task automatic waitDone(input int n, input string name);
        int budget = n * NB * 30 + 100;
        int c = 0;
        while (doneQ.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (doneQ.size() < n) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: done count %0d, required %0d", name, doneQ.size(), n);
        end
    endtask

    // Round-robin at block granularity: ties go to the requester not served last.
    task automatic runScenario(input int n0, input int n1, input bit randomData, input string name);
        logic [W-1:0] b0[$];
        logic [W-1:0] b1[$];
        logic [W-1:0] blk;
        int i0 = 0, i1 = 0, g, last;
        for (int j = 0; j < n0 + n1; j++) begin
            for (int k = 0; k < NB; k++)
                blk[W-1-8*k -: 8] = randomData ? 8'($urandom) : 8'(k + 16 * j);
            if (j < n0) b0.push_back(blk);
            else b1.push_back(blk);
        end
        foreach (b0[j]) req0Q.push_back(b0[j]);
        foreach (b1[j]) req1Q.push_back(b1[j]);
        last = lastGrant;
        while (i0 < n0 || i1 < n1) begin
            if (i0 < n0 && i1 < n1) g = 1 - last;
            else g = (i0 < n0) ? 0 : 1;
            expOrder.push_back(g);
            if (g == 1) begin expBlocks.push_back(b1[i1]); i1++; end
            else begin expBlocks.push_back(b0[i0]); i0++; end
            last = g;
        end
        lastGrant = last;
        waitDone(n0 + n1, name);
        repeat (3) @(negedge clk);
        checkOutput(name);
    endtask

    task automatic checkOutput(input string name);
        logic [W-1:0] got;
        compared++;
        if (gotBytes.size() !== expBlocks.size() * NB) begin
            mismatched++;
            $display("[TB] FAIL %s_byte_count: got %0d, required %0d", name, gotBytes.size(), expBlocks.size() * NB);
        end
        foreach (expBlocks[i]) begin
            compared++;
            if (i >= grantQ.size() || grantQ[i] !== expOrder[i]) begin
                mismatched++;
                $display("[TB] FAIL %s_grant%0d: got %0d, required %0d", name, i,
                         (i < grantQ.size()) ? grantQ[i] : -1, expOrder[i]);
            end
            compared++;
            if (i >= doneQ.size() || doneQ[i] !== expOrder[i]) begin
                mismatched++;
                $display("[TB] FAIL %s_done_id%0d: got %0d, required %0d", name, i,
                         (i < doneQ.size()) ? doneQ[i] : -1, expOrder[i]);
            end
            got = '0;
            for (int k = 0; k < NB; k++)
                if (i * NB + k < gotBytes.size()) got[W-1-8*k -: 8] = gotBytes[i * NB + k];
            compared++;
            if (got !== expBlocks[i]) begin
                mismatched++;
                $display("[TB] FAIL %s_block%0d: got %h, required %h", name, i, got, expBlocks[i]);
            end
        end
    endtask

    task automatic checkIdleOutputs(input string name);
        compared++;
        if ({txStart, txData, req0Ready, req1Ready, ctrlBusy, done, doneId} !== 14'h0) begin
            mismatched++;
            $display("[TB] FAIL %s: start=%0b data=%h rdy0=%0b rdy1=%0b busy=%0b done=%0b id=%0b, required all 0",
                     name, txStart, txData, req0Ready, req1Ready, ctrlBusy, done, doneId);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checkIdleOutputs("reset_asserted");
        doReset();
        checkIdleOutputs("reset_released");
    endtask

    task automatic test_basic();
        doReset();
        runScenario(1, 0, 1'b0, "basic");
    endtask

    task automatic test_back_to_back();
        doReset();
        runScenario(1, 1, 1'b1, "both_valid");
        compared++;
        if (grantCyc.size() < 2 || doneCyc.size() < 1 || grantCyc[1] - doneCyc[0] !== 1) begin
            mismatched++;
            $display("[TB] FAIL regrant_gap: got %0d cycles, required 1",
                     (grantCyc.size() >= 2 && doneCyc.size() >= 1) ? grantCyc[1] - doneCyc[0] : -1);
        end
    endtask

    task automatic test_round_robin();
        doReset();
        runScenario(2, 2, 1'b1, "round_robin");
        doReset();
        runScenario($urandom_range(1, 3), $urandom_range(0, 3), 1'b1, "random_mix");
    endtask

    task automatic test_reset_mid_block();
        int c = 0;
        doReset();
        req0Q.push_back({$urandom, $urandom, $urandom, $urandom});
        while (gotBytes.size() < 6 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        compared++;
        if (gotBytes.size() < 6) begin
            mismatched++;
            $display("[TB] FAIL midblock_reach_byte5: got %0d bytes, required 6", gotBytes.size());
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        req0Q.delete();
        #1;
        checkIdleOutputs("midblock_async_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        compared++;
        if (doneQ.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL midblock_no_done: got %0d done pulses, required 0", doneQ.size());
        end
        lastGrant = 1;
        clearRecords();
        runScenario(0, 1, 1'b1, "after_reset");
    endtask

    task automatic test_single_byte();
        int c = 0, starts = 0;
        bit earlyDone = 1'b0;
        logic [7:0] val;
        val = 8'($urandom);
        busy8 = 1'b0;
        d8 = val;
        v8 = 1'b1;
        while (!rdy80 && c < 20) begin
            @(negedge clk);
            c++;
        end
        v8 = 1'b0;
        compared++;
        if (!(rdy80 && st8 && td8 === val)) begin
            mismatched++;
            $display("[TB] FAIL w8_start: ready=%0b start=%0b data=%h, required 1 1 %h", rdy80, st8, td8, val);
        end
        starts = st8 ? 1 : 0;
        @(negedge clk);
        busy8 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done8) earlyDone = 1'b1;
            if (st8) starts++;
        end
        busy8 = 1'b0;
        @(negedge clk);
        compared++;
        if (!(done8 === 1'b1 && did8 === 1'b0 && obusy8 === 1'b0 && !earlyDone)) begin
            mismatched++;
            $display("[TB] FAIL w8_done: done=%0b id=%0b busy=%0b early=%0b, required 1 0 0 0",
                     done8, did8, obusy8, earlyDone);
        end
        compared++;
        if (starts !== 1) begin
            mismatched++;
            $display("[TB] FAIL w8_start_count: got %0d, required 1", starts);
        end
    endtask

    initial begin
        rst = 1'b1;
        v8 = 1'b0; d8 = 8'h00; busy8 = 1'b0;
        lastGrant = 1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_round_robin();
        test_reset_mid_block();
        test_single_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
